// File: rtl/selector_pkg.sv
// Shared definitions for the gear-selector front end and the downstream
// selection FSM: button indices, arbitration priority and lockout states.
package selector_pkg;

  localparam int NUM_BTN = 4;

  // Bit positions of each button in every 4-bit button vector.
  localparam int IDX_D = 0;
  localparam int IDX_N = 1;
  localparam int IDX_R = 2;
  localparam int IDX_P = 3;

  // Lockout FSM: IDLE accepts one press, HOLD waits for all buttons released.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sel_state_t;

  // Fixed priority P > N > R > D; Park wins because it is the safe state.
  function automatic logic [NUM_BTN-1:0] pick_priority(input logic [NUM_BTN-1:0] r);
    logic [NUM_BTN-1:0] g;
    g = '0;
    if (r[IDX_P])      g[IDX_P] = 1'b1;
    else if (r[IDX_N]) g[IDX_N] = 1'b1;
    else if (r[IDX_R]) g[IDX_R] = 1'b1;
    else if (r[IDX_D]) g[IDX_D] = 1'b1;
    return g;
  endfunction

  // True when more than one press competes in the same cycle.
  function automatic logic more_than_one(input logic [NUM_BTN-1:0] r);
    return ($countones(r) > 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: multi-flop synchroniser, counter-based debounce of the
// synchronised level, and rising-edge detection of the debounced level.
module debounce_channel #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic                   stable_q;

  assign sync = sync_ff[SYNC_STAGES-1];

  // Synchroniser chain: raw enters bit 0, the last bit is the usable level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
    end
  end

  // Debounce: the new level is accepted only after DB_CYCLES consecutive
  // disagreeing cycles; any agreeing cycle restarts the count, so cnt never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = stable & ~stable_q;

endmodule

// File: rtl/selector_input_conditioner.sv
// Gear-selector front end: four debounced button channels feeding a
// one-press-at-a-time lockout that emits single-cycle D/N/R/P requests.
module selector_input_conditioner
  import selector_pkg::*;
#(
  parameter int DB_CYCLES   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_d,
  input  logic       btn_n,
  input  logic       btn_r,
  input  logic       btn_p,
  output logic       D,
  output logic       N,
  output logic       R,
  output logic       P,
  output logic       conflict,
  output logic [3:0] held
);

  logic [NUM_BTN-1:0] raw_vec;
  logic [NUM_BTN-1:0] stable_vec;
  logic [NUM_BTN-1:0] rise_vec;
  logic [NUM_BTN-1:0] rise_p0;
  logic [NUM_BTN-1:0] req_p1;
  logic               conflict_p1;
  sel_state_t         state;

  assign raw_vec[IDX_D] = btn_d;
  assign raw_vec[IDX_N] = btn_n;
  assign raw_vec[IDX_R] = btn_r;
  assign raw_vec[IDX_P] = btn_p;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[i]),
      .stable(stable_vec[i]),
      .rise  (rise_vec[i])
    );
  end

  assign held = stable_vec;

  // Stage p0: register the edge pulses so arbitration sees only flop outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_p0 <= '0;
    end else begin
      rise_p0 <= rise_vec;
    end
  end

  // Stage p1: lockout FSM with registered request and conflict outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      req_p1      <= '0;
      conflict_p1 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_p1      <= pick_priority(rise_p0);
          conflict_p1 <= more_than_one(rise_p0);
          if (|rise_p0) state <= ST_HOLD;
        end
        ST_HOLD: begin
          // Presses while locked out are dropped and flagged; release of
          // every button is required before the next request is accepted.
          req_p1      <= '0;
          conflict_p1 <= |rise_p0;
          if (stable_vec == '0) state <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          req_p1      <= '0;
          conflict_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign D        = req_p1[IDX_D];
  assign N        = req_p1[IDX_N];
  assign R        = req_p1[IDX_R];
  assign P        = req_p1[IDX_P];
  assign conflict = conflict_p1;

endmodule

// File: tb/tb_selector_input_conditioner.sv
// Bench for selector_input_conditioner: behavioural model compared every
// cycle, directed scenarios with literal latency/count expectations, and a
// randomized button phase.
module tb_selector_input_conditioner;

  localparam int SS = 2;
  localparam int DB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_d = 1'b0, btn_n = 1'b0, btn_r = 1'b0, btn_p = 1'b0;
  logic       D, N, R, P, conflict;
  logic [3:0] held;

  selector_input_conditioner #(.DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset),
    .btn_d(btn_d), .btn_n(btn_n), .btn_r(btn_r), .btn_p(btn_p),
    .D(D), .N(N), .R(R), .P(P), .conflict(conflict), .held(held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model. Each button's level, seen SS edges late, must disagree
  // with the accepted level for DB consecutive edges before it is accepted.
  // A newly accepted high level is offered to the lockout two edges later.
  // The lockout grants one press (P>N>R>D) then ignores presses, flagging
  // them, until every accepted level is low.
  bit [3:0] pipe [SS];
  int       run [4];
  bit [3:0] m_stable, r1, r2, ev, hv, din, nr;
  bit       locked;
  bit       e_d, e_n, e_r, e_p, e_c;

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SS; s++) pipe[s] = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      m_stable = '0; r1 = '0; r2 = '0; locked = 1'b0;
      {e_d, e_n, e_r, e_p, e_c} = '0;
    end else begin
      ev = r2;
      hv = m_stable;
      {e_d, e_n, e_r, e_p, e_c} = '0;
      if (!locked) begin
        if (ev != 0) begin
          if (ev[3])      e_p = 1'b1;
          else if (ev[1]) e_n = 1'b1;
          else if (ev[2]) e_r = 1'b1;
          else            e_d = 1'b1;
          e_c = ($countones(ev) > 1);
          locked = 1'b1;
        end
      end else begin
        e_c = (ev != 0);
        if (hv == 0) locked = 1'b0;
      end
      din = pipe[SS-1];
      nr = '0;
      for (int i = 0; i < 4; i++) begin
        if (din[i] != m_stable[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            m_stable[i] = din[i];
            run[i] = 0;
            if (din[i]) nr[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
      r2 = r1;
      r1 = nr;
      for (int s = SS - 1; s > 0; s--) pipe[s] = pipe[s-1];
      pipe[0] = {btn_p, btn_r, btn_n, btn_d};
    end
  end

  // Per-cycle comparison against the model plus exclusivity and width rules.
  bit       started = 1'b0;
  logic [3:0] prev_req = '0;
  int cnt_d = 0, cnt_n = 0, cnt_r = 0, cnt_p = 0, cnt_c = 0;

  always @(negedge clk) begin
    if (started) begin
      check("D", int'(D), int'(e_d));
      check("N", int'(N), int'(e_n));
      check("R", int'(R), int'(e_r));
      check("P", int'(P), int'(e_p));
      check("conflict", int'(conflict), int'(e_c));
      check("held", int'(held), int'(m_stable));
      check("onehot", int'($countones({D, N, R, P}) <= 1), 1);
      check("width", int'((prev_req & {P, R, N, D}) != 0), 0);
      prev_req = {P, R, N, D};
      if (D) cnt_d++;
      if (N) cnt_n++;
      if (R) cnt_r++;
      if (P) cnt_p++;
      if (conflict) cnt_c++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic out_bit(input int which);
    logic [3:0] v;
    v = {P, R, N, D};
    return v[which];
  endfunction

  // Counts edges from the first edge that samples the new input until the
  // chosen request is seen; -1 if it never comes within the budget.
  task automatic measure(input int which, output int k);
    k = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_bit(which)) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    int k;
    int c_d, c_n, c_r, c_p, c_c;
    int dur [4];
    logic [3:0] lvl;

    reset = 1'b1;
    @(negedge clk);
    started = 1'b1;
    check("reset_held", int'(held), 0);
    check("reset_req", int'({D, N, R, P, conflict}), 0);
    tick(2);
    reset = 1'b0;
    tick(3);

    // Clean Park press
    c_d = cnt_d; c_n = cnt_n; c_r = cnt_r; c_p = cnt_p;
    btn_p = 1'b1;
    measure(3, k);
    check("clean_latency", k, 19);
    tick(20);
    check("clean_held_p", int'(held[3]), 1);
    check("clean_p_count", cnt_p - c_p, 1);
    check("clean_dnr_count", (cnt_d - c_d) + (cnt_n - c_n) + (cnt_r - c_r), 0);
    btn_p = 1'b0;
    tick(40);

    // Glitches and bounce on Drive
    c_d = cnt_d;
    btn_d = 1'b1; tick(3);  btn_d = 1'b0; tick(20);
    btn_d = 1'b1; tick(10); btn_d = 1'b0; tick(20);
    for (int t = 0; t < 5; t++) begin
      btn_d = 1'b1; tick(2); btn_d = 1'b0; tick(2);
    end
    check("glitch_no_pulse", cnt_d - c_d, 0);
    check("glitch_held", int'(held), 0);
    btn_d = 1'b1;
    measure(0, k);
    check("bounce_latency", k, 19);
    tick(30);
    check("bounce_d_count", cnt_d - c_d, 1);
    btn_d = 1'b0;
    tick(40);

    // Simultaneous Drive and Park
    c_d = cnt_d; c_c = cnt_c;
    btn_d = 1'b1; btn_p = 1'b1;
    measure(3, k);
    check("simul_latency", k, 19);
    check("simul_conflict", int'(conflict), 1);
    tick(30);
    btn_d = 1'b0; btn_p = 1'b0;
    tick(40);
    check("simul_no_d", cnt_d - c_d, 0);
    check("simul_conflict_count", cnt_c - c_c, 1);

    // Lockout: Reverse pressed while Neutral is held
    c_n = cnt_n; c_r = cnt_r; c_c = cnt_c;
    btn_n = 1'b1; tick(30);
    btn_r = 1'b1; tick(40);
    check("lock_n_count", cnt_n - c_n, 1);
    check("lock_r_count", cnt_r - c_r, 0);
    check("lock_conflict", cnt_c - c_c, 1);
    btn_n = 1'b0; btn_r = 1'b0;
    tick(40);
    btn_r = 1'b1;
    measure(2, k);
    check("unlock_r_latency", k, 19);
    tick(25);
    btn_r = 1'b0;
    tick(40);
    check("unlock_r_count", cnt_r - c_r, 1);

    // Reset mid-debounce, button released afterwards
    c_d = cnt_d;
    btn_d = 1'b1; tick(10);
    reset = 1'b1; tick(1);
    reset = 1'b0; btn_d = 1'b0;
    tick(40);
    check("rst_mid_no_pulse", cnt_d - c_d, 0);
    check("rst_mid_held", int'(held), 0);

    // Reset mid-debounce, button held through reset
    btn_d = 1'b1; tick(10);
    reset = 1'b1; tick(1);
    reset = 1'b0;
    measure(0, k);
    check("rst_held_latency", k, 19);
    tick(30);
    check("rst_held_d_count", cnt_d - c_d, 1);
    btn_d = 1'b0;
    tick(40);

    // Randomized button activity with occasional resets
    for (int i = 0; i < 4; i++) dur[i] = 0;
    lvl = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (dur[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                               : int'($urandom_range(10, 60));
        end
        dur[i]--;
      end
      {btn_p, btn_r, btn_n, btn_d} = lvl;
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    {btn_p, btn_r, btn_n, btn_d} = '0;
    tick(60);
    check("final_held", int'(held), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
